// File: rtl/seg7_disp_ctrl.sv
// Memory-mapped source selector, scroller and change-strobe
// feeding the 8-digit hex 7-segment driver.
module seg7_disp_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
  parameter int          SCROLL_DIV = 25_000_000,
  parameter int          DIV_W      = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic [1:0]  sw_sel,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        o_cs,
  output logic [31:0] o_data
);

  localparam logic [29:0] A_DATA = BASE_ADDR[31:2];
  localparam logic [29:0] A_CTRL = A_DATA + 30'd1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SCROLL_DIV - 1);

  logic [31:0]      r_data;
  logic [2:0]       r_ctrl;
  logic [2:0]       r_ofs;
  logic [DIV_W-1:0] r_div;

  logic        w_hit_data;
  logic        w_hit_ctrl;
  logic        w_wr_data;
  logic        w_wr_ctrl;
  logic        w_scroll;
  logic        w_dir;
  logic        w_freeze;
  logic        w_tc;
  logic [63:0] w_dd;
  logic [31:0] w_rot;
  logic [31:0] w_sel;
  logic        w_unused;

  assign w_hit_data = (mem_addr[31:2] == A_DATA);
  assign w_hit_ctrl = (mem_addr[31:2] == A_CTRL);
  assign w_wr_data  = mem_we && w_hit_data;
  assign w_wr_ctrl  = mem_we && w_hit_ctrl;

  assign w_scroll = r_ctrl[0];
  assign w_dir    = r_ctrl[1];
  assign w_freeze = r_ctrl[2];
  assign w_tc     = (r_div == DIV_LAST);

  always_comb begin
    mem_rdata = 32'h0;
    if (w_hit_data)
      mem_rdata = r_data;
    else if (w_hit_ctrl)
      mem_rdata = {29'h0, r_ctrl};
  end

  // Right-rotate by 4*(8-ofs) equals left-rotate by 4*ofs,
  // so one rotator serves both directions.
  assign w_dd  = {r_data, r_data} << {r_ofs, 2'b00};
  assign w_rot = w_dd[63:32];

  always_comb begin
    w_sel = w_rot;
    unique case (sw_sel)
      2'd0: w_sel = w_rot;
      2'd1: w_sel = pc;
      2'd2: w_sel = instr;
      2'd3: w_sel = {29'h0, r_ctrl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= 32'h0;
      r_ctrl <= 3'h0;
    end else begin
      if (w_wr_data)
        r_data <= mem_wdata;
      if (w_wr_ctrl)
        r_ctrl <= mem_wdata[2:0];
    end
  end

  // A DATA store restarts the scroll from the unrotated word.
  always_ff @(posedge clk) begin
    if (reset || w_wr_data || !w_scroll) begin
      r_ofs <= 3'h0;
      r_div <= '0;
    end else if (!w_freeze) begin
      if (w_tc) begin
        r_div <= '0;
        r_ofs <= w_dir ? r_ofs - 3'd1 : r_ofs + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data <= 32'h0;
      o_cs   <= 1'b0;
    end else if (w_freeze) begin
      o_cs <= 1'b0;
    end else if (w_sel != o_data) begin
      o_data <= w_sel;
      o_cs   <= 1'b1;
    end else begin
      o_cs <= 1'b0;
    end
  end

  assign w_unused = ^{mem_addr[1:0], mem_wdata[31:3],
                      w_dd[31:0]};

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Directed bench for seg7_disp_ctrl with a 4-cycle
// scroll divider; immediate assertions at each check.
module tb_seg7_disp_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  sw_sel;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        o_cs;
  logic [31:0] o_data;

  int checks   = 0;
  int failures = 0;

  seg7_disp_ctrl #(
    .BASE_ADDR (BASE),
    .SCROLL_DIV(4),
    .DIV_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .sw_sel   (sw_sel),
    .pc       (pc),
    .instr    (instr),
    .o_cs     (o_cs),
    .o_data   (o_data)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    mem_addr = a;
    #1;
    chk(tag, mem_rdata, exp);
    mem_addr = 32'h0;
  endtask

  task automatic out(input string tag,
                     input logic [31:0] d,
                     input logic cs);
    chk({tag, "_data"}, o_data, d);
    chk({tag, "_cs"}, {31'h0, o_cs}, {31'h0, cs});
  endtask

  initial begin
    reset     = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    sw_sel    = 2'd0;
    pc        = 32'h0;
    instr     = 32'h0;
    tick(2);
    reset = 1'b0;
    out("rst", 32'h0, 1'b0);
    rd("rst_rd_data", BASE, 32'h0);
    rd("rst_rd_ctrl", BASE + 4, 32'h0);

    store(BASE, 32'h1234_5678);
    out("t1_store_edge", 32'h0, 1'b0);
    tick();
    out("t1_load", 32'h1234_5678, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      out("t1_idle", 32'h1234_5678, 1'b0);
    end
    rd("t1_rd_data", BASE, 32'h1234_5678);

    store(BASE + 4, 32'h1);
    tick(4);
    out("t2_pre", 32'h1234_5678, 1'b0);
    tick();
    out("t2_step1", 32'h2345_6781, 1'b1);
    tick(4);
    out("t2_step2", 32'h3456_7812, 1'b1);
    tick(24);
    out("t2_wrap", 32'h1234_5678, 1'b1);

    store(BASE + 4, 32'h0);
    tick();
    store(BASE + 4, 32'h3);
    tick(4);
    out("t3_pre", 32'h1234_5678, 1'b0);
    tick();
    out("t3_step1", 32'h8123_4567, 1'b1);
    tick(4);
    out("t3_step2", 32'h7812_3456, 1'b1);
    store(BASE, 32'h1234_5678);
    tick();
    out("t3_restart", 32'h1234_5678, 1'b1);

    store(BASE + 4, 32'h5);
    store(BASE, 32'hDEAD_BEEF);
    tick();
    out("t4_frozen", 32'h1234_5678, 1'b0);
    tick(3);
    out("t4_frozen2", 32'h1234_5678, 1'b0);
    rd("t4_rd_data", BASE, 32'hDEAD_BEEF);
    store(BASE + 4, 32'h1);
    tick();
    out("t4_thaw", 32'hDEAD_BEEF, 1'b1);

    sw_sel = 2'd1;
    pc     = 32'h0040_0000;
    tick();
    out("t5_pc0", 32'h0040_0000, 1'b1);
    pc = 32'h0040_0004;
    tick();
    out("t5_pc1", 32'h0040_0004, 1'b1);
    tick();
    out("t5_pc_idle", 32'h0040_0004, 1'b0);
    rd("t5_rd_ctrl", BASE + 4, 32'h1);
    sw_sel = 2'd2;
    instr  = 32'h00A0_0093;
    tick();
    out("t5_instr", 32'h00A0_0093, 1'b1);
    sw_sel = 2'd3;
    tick();
    out("t5_ctrl", 32'h1, 1'b1);

    store(BASE + 8, 32'hFFFF_FFFF);
    store(BASE - 4, 32'hFFFF_FFFF);
    rd("t6_rd_data", BASE, 32'hDEAD_BEEF);
    rd("t6_rd_ctrl", BASE + 4, 32'h1);
    rd("t6_rd_miss", BASE + 8, 32'h0);
    sw_sel = 2'd0;
    tick(7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out("t6_reset", 32'h0, 1'b0);
    rd("t6_rst_ctrl", BASE + 4, 32'h0);
    tick(3);
    out("t6_post", 32'h0, 1'b0);
    store(BASE, 32'hCAFE_F00D);
    tick();
    out("t6_ofs0", 32'hCAFE_F00D, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
